// File: rtl/keyword_recognizer.sv
// Streaming keyword recognizer: one character per valid cycle,
// per-keyword progress counters, pulse or toggle outputs, idle timeout.
module keyword_recognizer #(
    parameter int CHAR_W  = 8,
    parameter int MAX_LEN = 12,
    parameter int NUM_KW  = 4,
    parameter logic [NUM_KW*MAX_LEN*CHAR_W-1:0] KW_TABLE = {
        {24'd0, "CISUMYALP"},
        {40'd0, "TOHSITI"},
        {32'd0, "DLOCSITI"},
        {72'd0, "NUR"}
    },
    parameter logic [NUM_KW*4-1:0] KW_LEN  = {4'd9, 4'd7, 4'd8, 4'd3},
    parameter logic [NUM_KW-1:0]   KW_MODE = 4'b0110,
    parameter int TIMEOUT = 16,
    localparam int IDX_W = (NUM_KW > 1) ? $clog2(NUM_KW) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              char_valid,
    input  logic [CHAR_W-1:0] char,
    output logic [NUM_KW-1:0] kw_out,
    output logic              kw_hit,
    output logic [IDX_W-1:0]  kw_idx
);

    localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IW-1:0] TO = IW'(TIMEOUT);

    logic [IW-1:0]     idle_q, idle_d;
    logic              idle_expire;
    logic [NUM_KW-1:0] done_vec;

    logic [NUM_KW-1:0] kw_out_q, kw_out_d;
    logic              kw_hit_q, kw_hit_d;
    logic [IDX_W-1:0]  kw_idx_q, kw_idx_d;

    // Idle counter saturates at TIMEOUT; progress is flushed on the edge it gets there.
    always_comb begin
        idle_d      = idle_q;
        idle_expire = 1'b0;
        if (char_valid) begin
            idle_d = '0;
        end else if (TIMEOUT != 0) begin
            if (idle_q != TO) begin
                idle_d = idle_q + IW'(1);
            end
            idle_expire = (idle_d == TO);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end

    for (genvar g = 0; g < NUM_KW; g++) begin : g_kw
        localparam logic [3:0] LEN = KW_LEN[4*g +: 4];

        logic [15:0][CHAR_W-1:0] kw_chars;
        logic [3:0]              prog_q, prog_d;
        logic                    done;

        for (genvar i = 0; i < 16; i++) begin : g_ch
            if (i < MAX_LEN) begin : g_in
                assign kw_chars[i] = KW_TABLE[(g*MAX_LEN + i)*CHAR_W +: CHAR_W];
            end else begin : g_pad
                assign kw_chars[i] = '0;
            end
        end

        // Restart on the first character only; no deeper back-off.
        always_comb begin
            prog_d = prog_q;
            done   = 1'b0;
            if (LEN != 4'd0 && char_valid) begin
                if (char == kw_chars[prog_q]) begin
                    if (prog_q + 4'd1 == LEN) begin
                        done   = 1'b1;
                        prog_d = 4'd0;
                    end else begin
                        prog_d = prog_q + 4'd1;
                    end
                end else if (char == kw_chars[0]) begin
                    if (LEN == 4'd1) begin
                        done   = 1'b1;
                        prog_d = 4'd0;
                    end else begin
                        prog_d = 4'd1;
                    end
                end else begin
                    prog_d = 4'd0;
                end
            end else if (idle_expire) begin
                prog_d = 4'd0;
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                prog_q <= 4'd0;
            end else begin
                prog_q <= prog_d;
            end
        end

        assign done_vec[g] = done;
    end

    always_comb begin
        kw_out_d = (KW_MODE & (kw_out_q ^ done_vec)) | (~KW_MODE & done_vec);
        kw_hit_d = |done_vec;
        kw_idx_d = '0;
        for (int k = NUM_KW - 1; k >= 0; k--) begin
            if (done_vec[k]) begin
                kw_idx_d = IDX_W'(k);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            kw_out_q <= '0;
            kw_hit_q <= 1'b0;
            kw_idx_q <= '0;
        end else begin
            kw_out_q <= kw_out_d;
            kw_hit_q <= kw_hit_d;
            kw_idx_q <= kw_idx_d;
        end
    end

    assign kw_out = kw_out_q;
    assign kw_hit = kw_hit_q;
    assign kw_idx = kw_idx_q;

endmodule

// File: tb/tb_keyword_recognizer.sv
// Vector-table bench for keyword_recognizer: default table, a two-keyword
// overlap table and a short-timeout instance share one input stream.
module tb_keyword_recognizer;

    typedef struct {
        bit         rst;
        bit         vld;
        logic [7:0] ch;
        int         dut;
        logic [3:0] eout;
        bit         ehit;
        logic [1:0] eidx;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       char_valid = 1'b0;
    logic [7:0] char = 8'h00;

    logic [3:0] out0, out2;
    logic [1:0] out1;
    logic       hit0, hit1, hit2;
    logic [1:0] idx0, idx2;
    logic       idx1;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vecs[$];
    vec_t exp_q[$];

    always #5 clock = ~clock;

    keyword_recognizer u_def (
        .clock(clock), .reset(reset), .char_valid(char_valid), .char(char),
        .kw_out(out0), .kw_hit(hit0), .kw_idx(idx0)
    );

    keyword_recognizer #(
        .CHAR_W(8), .MAX_LEN(3), .NUM_KW(2),
        .KW_TABLE({8'd0, "BA", "BAA"}),
        .KW_LEN({4'd2, 4'd3}),
        .KW_MODE(2'b00),
        .TIMEOUT(0)
    ) u_ovl (
        .clock(clock), .reset(reset), .char_valid(char_valid), .char(char),
        .kw_out(out1), .kw_hit(hit1), .kw_idx(idx1)
    );

    keyword_recognizer #(.TIMEOUT(4)) u_to (
        .clock(clock), .reset(reset), .char_valid(char_valid), .char(char),
        .kw_out(out2), .kw_hit(hit2), .kw_idx(idx2)
    );

    task automatic add(input bit r, input bit v, input logic [7:0] c,
                       input int d, input logic [3:0] o, input bit h,
                       input logic [1:0] i);
        vec_t e;
        e.rst = r; e.vld = v; e.ch = c; e.dut = d;
        e.eout = o; e.ehit = h; e.eidx = i;
        vecs.push_back(e);
    endtask

    task automatic add_str(input string s, input int d, input logic [3:0] o);
        for (int k = 0; k < s.len(); k++) begin
            add(0, 1, s[k], d, o, 0, 0);
        end
    endtask

    task automatic add_idle(input int n, input int d, input logic [3:0] o);
        for (int k = 0; k < n; k++) begin
            add(0, 0, 8'h00, d, o, 0, 0);
        end
    endtask

    task automatic check(input string name, input int vi,
                         input logic [3:0] got, input logic [3:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s vec%0d: got %b, want %b", name, vi, got, want);
        end
    endtask

    initial begin
        vec_t e;
        logic [3:0] a_out;
        logic       a_hit;
        logic [1:0] a_idx;

        // reset state of each instance
        add(1, 0, 8'h00, 0, 4'b0000, 0, 0);
        add(1, 0, 8'h00, 1, 4'b0000, 0, 0);
        add(1, 0, 8'h00, 2, 4'b0000, 0, 0);

        // overlap table: AAB fires both, AAAB fires only AB
        add_str("ZAA", 1, 4'b0000);
        add(0, 1, "B", 1, 4'b0011, 1, 0);
        add_str("AAA", 1, 4'b0000);
        add(0, 1, "B", 1, 4'b0010, 1, 1);
        add_idle(1, 1, 4'b0000);

        // timeout 4: three idle cycles keep progress, four discard it
        add_str("ZRU", 2, 4'b0000);
        add_idle(3, 2, 4'b0000);
        add(0, 1, "N", 2, 4'b0001, 1, 0);
        add_str("RU", 2, 4'b0000);
        add_idle(4, 2, 4'b0000);
        add(0, 1, "N", 2, 4'b0000, 0, 0);

        // RUN pulse
        add_str("RU", 0, 4'b0000);
        add(0, 1, "N", 0, 4'b0001, 1, 0);
        add_idle(1, 0, 4'b0000);

        // ITISCOLD twice toggles back
        add_str("ITISCOL", 0, 4'b0000);
        add(0, 1, "D", 0, 4'b0010, 1, 1);
        add_idle(1, 0, 4'b0010);
        add_str("ITISCOL", 0, 4'b0010);
        add(0, 1, "D", 0, 4'b0000, 1, 1);

        // ITISHOT toggles on, PLAYMUSIC pulses
        add_str("ITISHO", 0, 4'b0000);
        add(0, 1, "T", 0, 4'b0100, 1, 2);
        add_str("PLAYMUSI", 0, 4'b0100);
        add(0, 1, "C", 0, 4'b1100, 1, 3);
        add_idle(1, 0, 4'b0100);

        // restart on repeated first character
        add_str("RRU", 0, 4'b0100);
        add(0, 1, "N", 0, 4'b0101, 1, 0);
        add_idle(1, 0, 4'b0100);

        // reset mid-word wins over char_valid and clears toggles
        add_str("PLAYMU", 0, 4'b0100);
        add(1, 1, "S", 0, 4'b0000, 0, 0);
        add_str("SIC", 0, 4'b0000);
        add_str("PLAYMUSI", 0, 4'b0000);
        add(0, 1, "C", 0, 4'b1000, 1, 3);
        add_idle(1, 0, 4'b0000);

        for (int vi = 0; vi < vecs.size(); vi++) begin
            reset      = vecs[vi].rst;
            char_valid = vecs[vi].vld;
            char       = vecs[vi].ch;
            exp_q.push_back(vecs[vi]);
            @(posedge clock);
            #1;
            e = exp_q.pop_front();
            case (e.dut)
                0: begin a_out = out0; a_hit = hit0; a_idx = idx0; end
                1: begin a_out = {2'b00, out1}; a_hit = hit1; a_idx = {1'b0, idx1}; end
                default: begin a_out = out2; a_hit = hit2; a_idx = idx2; end
            endcase
            check("kw_out", vi, a_out, e.eout);
            check("kw_hit", vi, {3'b000, a_hit}, {3'b000, e.ehit});
            if (e.ehit || e.rst) begin
                check("kw_idx", vi, {2'b00, a_idx}, {2'b00, e.eidx});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
